// File: rtl/pixel_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_pkg
// Description : Shared types and constants for the pixel window reader:
//               FSM state encoding, colour-bar table, clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_window_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    STALL    = 2'd2
  } pwr_state_t;

  // RGB565 vertical colour bars, index 0 at the left edge of the screen
  localparam logic [7:0][15:0] BAR_TABLE = {
    16'h0000,   // 7 black
    16'h001F,   // 6 blue
    16'hF800,   // 5 red
    16'hF81F,   // 4 magenta
    16'h07E0,   // 3 green
    16'h07FF,   // 2 cyan
    16'hFFE0,   // 1 yellow
    16'hFFFF    // 0 white
  };

  // Number of bits needed to index 'value' distinct codes
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    while ((64'd1 << result) < value) result++;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_window_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_reader_if
// Description : Frame-buffer read FIFO port: read strobe, read data and the
//               FIFO empty flag. The reader is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_window_reader_if #(
  parameter int DATA_W = 16
);
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_empty;

  modport master (output rd_en, input rd_data, input fifo_empty);
  modport slave  (input rd_en, output rd_data, output fifo_empty);
endinterface
`default_nettype wire

// File: rtl/pixel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : pixel_delay_line
// Description : Fixed-depth shift register with asynchronous active-low
//               reset; dout is din delayed by DEPTH clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH*DEPTH-1:0] taps;

  generate
    if (DEPTH == 1) begin : g_single
      // single stage: plain register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps <= '0;
        else        taps <= din;
      end
    end else begin : g_chain
      // newest sample enters at the bottom, oldest leaves at the top
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps <= '0;
        else        taps <= {taps[WIDTH*(DEPTH-1)-1:0], din};
      end
    end
  endgenerate

  assign dout = taps[WIDTH*DEPTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/pixel_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_reader
// Description : Gates frame-buffer FIFO reads to an image window inside the
//               HDMI active area, substitutes a background colour elsewhere,
//               aligns output to the FIFO read latency and tracks frame
//               integrity (pixel count, underflow, error frame count).
//               Optional macro PIXEL_WINDOW_READER_PATTERN_EN adds a
//               pattern_en input that shows colour bars instead of the
//               background colour.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_window_reader
  import pixel_window_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                POS_W    = 11,
  parameter int                IMG_X0   = 0,
  parameter int                IMG_Y0   = 0,
  parameter int                IMG_W    = 640,
  parameter int                IMG_H    = 480,
  parameter logic [DATA_W-1:0] BG_COLOR = DATA_W'(16'h7FFF),
  parameter int                RD_LAT   = 1
) (
  input  logic               hdmi_clk,
  input  logic               rst_n,
  input  logic [POS_W-1:0]   pixel_xpos,
  input  logic [POS_W-1:0]   pixel_ypos,
  input  logic               data_req,
`ifdef PIXEL_WINDOW_READER_PATTERN_EN
  input  logic               pattern_en,
`endif
  pixel_window_reader_if.master fifo,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               sof,
  output logic               frame_ok,
  output logic               underflow,
  output logic [7:0]         err_frames
);

  localparam int                 FRAME_PIX = IMG_W * IMG_H;
  localparam int                 CNT_W     = clog2(64'(FRAME_PIX) + 64'd1);
  localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(FRAME_PIX);
  // Window origin and span held one bit wider than the coordinates so that
  // origin + size never wraps.
  localparam logic [POS_W:0]     X_LO      = (POS_W+1)'(IMG_X0);
  localparam logic [POS_W:0]     Y_LO      = (POS_W+1)'(IMG_Y0);
  localparam logic [POS_W+1:0]   W_SPAN    = (POS_W+2)'(IMG_W);
  localparam logic [POS_W+1:0]   H_SPAN    = (POS_W+2)'(IMG_H);
`ifdef PIXEL_WINDOW_READER_PATTERN_EN
  localparam int                 FLAG_W    = 5;
`else
  localparam int                 FLAG_W    = 1;
`endif

  pwr_state_t        state, state_nxt;
  logic [POS_W+1:0]  x_rel, y_rel;
  logic              in_win, sof_cond, uf_evt, book, frame_good;
  logic [CNT_W-1:0]  pix_cnt;
  logic [FLAG_W-1:0] flag_in, flag_dly;
  logic [DATA_W-1:0] fill_dly;

  // Window test: offset from the origin, a coordinate left of/above the
  // origin wraps to a huge value and fails the span compare.
  always_comb begin
    x_rel      = {2'b00, pixel_xpos} - {1'b0, X_LO};
    y_rel      = {2'b00, pixel_ypos} - {1'b0, Y_LO};
    sof_cond   = data_req && (pixel_xpos == '0) && (pixel_ypos == '0);
    in_win     = data_req && (x_rel < W_SPAN) && (y_rel < H_SPAN);
    fifo.rd_en = in_win && ((state == RUN) || sof_cond) && !fifo.fifo_empty;
    uf_evt     = in_win && (state == RUN) && fifo.fifo_empty;
    book       = sof_cond && (state != WAIT_SOF);
    frame_good = (pix_cnt == FRAME_CNT) && !underflow;
  end

  // FSM state register
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOF;
    else        state <= state_nxt;
  end

  // FSM next state; start of frame wins over a simultaneous underflow
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (sof_cond) state_nxt = RUN;
      RUN: begin
        if (sof_cond)    state_nxt = RUN;
        else if (uf_evt) state_nxt = STALL;
      end
      STALL:    if (sof_cond) state_nxt = RUN;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  // Frame integrity: pixel count, sticky underflow, end-of-frame verdict
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      frame_ok   <= 1'b0;
      underflow  <= 1'b0;
      err_frames <= 8'd0;
      sof        <= 1'b0;
    end else begin
      sof <= sof_cond;
      if (book) begin
        frame_ok  <= frame_good;
        if (!frame_good && (err_frames != 8'hFF)) err_frames <= err_frames + 8'd1;
        pix_cnt   <= {{(CNT_W-1){1'b0}}, fifo.rd_en};
        underflow <= uf_evt;
      end else begin
        if (fifo.rd_en && (pix_cnt != '1)) pix_cnt <= pix_cnt + 1'b1;
        if (uf_evt) underflow <= 1'b1;
      end
    end
  end

`ifdef PIXEL_WINDOW_READER_PATTERN_EN
  // Bars replace the background outside the window and while stalled
  always_comb begin
    flag_in  = {pattern_en && !fifo.rd_en && (!in_win || (state == STALL)),
                pixel_xpos[POS_W-1 -: 3], fifo.rd_en};
    fill_dly = flag_dly[4] ? DATA_W'(BAR_TABLE[flag_dly[3:1]]) : BG_COLOR;
  end
`else
  // Background is a constant colour
  always_comb begin
    flag_in  = fifo.rd_en;
    fill_dly = BG_COLOR;
  end
`endif

  pixel_delay_line #(.WIDTH(FLAG_W), .DEPTH(RD_LAT)) u_rd_dly (
    .clk   (hdmi_clk),
    .rst_n (rst_n),
    .din   (flag_in),
    .dout  (flag_dly)
  );

  pixel_delay_line #(.WIDTH(1), .DEPTH(RD_LAT + 1)) u_valid_dly (
    .clk   (hdmi_clk),
    .rst_n (rst_n),
    .din   (data_req),
    .dout  (out_valid)
  );

  // Capture FIFO data when the delayed read flag says it is valid
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)          out_data <= BG_COLOR;
    else if (flag_dly[0]) out_data <= fifo.rd_data;
    else                 out_data <= fill_dly;
  end

endmodule
`default_nettype wire

// File: doc/pixel_window_reader.md
Name: pixel_window_reader

Overview:
- Successor to the HDMI pixel-data gating stage. Sits between the frame-buffer read FIFO and the HDMI encoder.
- Issues FIFO reads only inside a parametrised image window (offset and size). Outside the window it substitutes a background colour.
- Aligns out_data to the FIFO read latency and tracks frame integrity: pixel count and underflow.
- Recovers from underflow at the next start of frame.

Parameters:
- DATA_W, 16, pixel width (RGB565 default)
- POS_W, 11, width of pixel_xpos/pixel_ypos
- IMG_X0, 0, window left column (active coordinates)
- IMG_Y0, 0, window top row
- IMG_W, 640, window width in pixels
- IMG_H, 480, window height in lines
- BG_COLOR, 16'h7FFF, colour driven outside the window or when not running
- RD_LAT, 1, FIFO read latency in cycles, range 1..4

Ports:
- hdmi_clk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- pixel_xpos  in  POS_W  active-area column of requested pixel
- pixel_ypos  in  POS_W  active-area row of requested pixel
- data_req  in  1  timing generator requests a pixel this cycle
- rd_data  in  DATA_W  FIFO read data, valid RD_LAT cycles after rd_en
- fifo_empty  in  1  FIFO empty flag
- rd_en  out  1  FIFO read strobe
- out_data  out  DATA_W  pixel to encoder
- out_valid  out  1  data_req delayed by RD_LAT+1
- sof  out  1  one-cycle start-of-frame pulse
- frame_ok  out  1  last completed frame read exactly IMG_W*IMG_H pixels without underflow
- underflow  out  1  sticky; set on first underflow, cleared at next sof
- err_frames  out  8  saturating count of frames with underflow or count mismatch

Behaviour:
- Reset (async, rst_n=0): state=WAIT_SOF; rd_en=0; out_data=BG_COLOR; out_valid=0; sof=0; frame_ok=0; underflow=0; err_frames=0; pixel counter=0; all delay lines cleared.
- sof_cond = data_req && pixel_xpos==0 && pixel_ypos==0. The sof output is that condition registered, so it pulses one cycle later.
- in_win = data_req && IMG_X0<=x<IMG_X0+IMG_W && IMG_Y0<=y<IMG_Y0+IMG_H.
  - Bounds are computed at POS_W+1 bits so they do not overflow.
  - Upper bounds are exclusive.
- rd_en = in_win && (state==RUN || sof_cond) && !fifo_empty. It is combinational from the inputs and state, so the FIFO sees it the same cycle.
- Underflow event = in_win && state==RUN && fifo_empty. No read is issued for that pixel.
- State machine:
  - WAIT_SOF: no reads. On sof_cond go to RUN; the (0,0) pixel is read in that same cycle if it is in the window.
  - RUN: on an underflow event go to STALL. On sof_cond stay in RUN and do end-of-frame bookkeeping.
  - STALL: no reads, background output. On sof_cond go to RUN with bookkeeping.
- Output path:
  - A delay line of depth RD_LAT carries the read flag; rd_data is registered into out_data when the delayed flag is 1, otherwise out_data=BG_COLOR.
  - out_data and out_valid are therefore RD_LAT+1 cycles after data_req.
- Pixel counter: width clog2(IMG_W*IMG_H+1), increments on each rd_en and saturates at all-ones.
- End-of-frame bookkeeping, on every sof_cond outside WAIT_SOF:
  - frame_ok <= (count==IMG_W*IMG_H) && !underflow.
  - err_frames increments, saturating at 255, if the frame was not ok.
  - Counter resets to 0, or to 1 if the (0,0) read is issued in the same cycle.
  - underflow clears.
- Simultaneous underflow and sof_cond: the sof takes priority, so the (0,0) pixel counts for the new frame. fifo_empty still blocks that read, and underflow is set for the new frame.
- A window that extends past the timing area is not an error; the pixel count is simply short, so frame_ok=0.

Optional Feature:
- Macro: PIXEL_WINDOW_READER_PATTERN_EN.
- When defined:
  - Adds input pattern_en (1 bit).
  - While pattern_en=1, out-of-window pixels and STALL pixels show 8 vertical colour bars, selected by x[POS_W-1:POS_W-3] through the same delay line, instead of BG_COLOR.
  - FIFO reads are unaffected.
- When undefined: no port, and BG_COLOR is used everywhere.

Decomposition:
- Package pixel_window_pkg: state enum (WAIT_SOF, RUN, STALL), the colour-bar constant table, and a clog2 helper.
- Sub-module pixel_delay_line (parametrised width and depth, async reset) for the read-flag and out_valid pipelines.

Test Plan:
- Defaults, FIFO never empty, two full frames of 800x525 timing:
  - exactly 307200 rd_en per frame;
  - frame_ok=1 after the second sof;
  - out_data equals rd_data delayed by 2 cycles in the window;
  - out_data=16'h7FFF at y=480..524.
- IMG_X0=100, IMG_Y0=50, IMG_W=64, IMG_H=32: first rd_en at (100,50); no rd_en at x=164 or y=82; 2048 reads per frame.
- fifo_empty forced high for 1 cycle mid-frame:
  - underflow=1 and state=STALL;
  - rd_en=0 for the rest of the frame;
  - next sof gives frame_ok=0, err_frames=1, and reads resume at (0,0).
- rst_n asserted mid-line: all outputs at reset values immediately; no rd_en until the next (0,0) data_req.
- RD_LAT=3: out_valid and out_data lag data_req by 4 cycles.
- With PIXEL_WINDOW_READER_PATTERN_EN and pattern_en=1, small window: out-of-window pixels follow the bar table; in-window data is unchanged.
